// File: rtl/jpeg_pkg.sv
// Shared constants and state type for the JPEG stuffer writers.
// The RST state exists only when JPEG_RESTART_EN is defined.
package jpeg_pkg;

  localparam logic [7:0]  SOI         = 8'hD8;
  localparam logic [7:0]  EOI         = 8'hD9;
  localparam logic [7:0]  RST0        = 8'hD0;
  localparam logic [7:0]  FILL        = 8'hFF;
  localparam logic [31:0] NOSTUFF_ALL = 32'h8080_8080;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SCAN = 3'd2,
`ifdef JPEG_RESTART_EN
    S_RST  = 3'd3,
`endif
    S_EOI  = 3'd4
  } state_t;

endpackage

// File: rtl/jpeg_issue_pacer.sv
// Minimum-spacing pacer for stuffer word pushes.
// The gap counter reloads on every fire; permit is high once it has run down to zero.
module jpeg_issue_pacer #(
  parameter int ISSUE_GAP = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic permit
);

  localparam int CW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

  logic [CW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (fire) begin
      gap_cnt <= CW'(ISSUE_GAP - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - CW'(1);
    end
  end

  assign permit = (gap_cnt == '0);

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Frame scheduler feeding the byte stuffer: header ROM, entropy words, optional RSTm markers, then EOI.
// Restart-marker insertion is compiled in with JPEG_RESTART_EN.
//
// state  | meaning
// IDLE   | waiting for frame_start
// HDR    | streaming header ROM words, unstuffed
// SCAN   | passing entropy words through, stuffed
// RST    | emitting one RSTm marker word (JPEG_RESTART_EN only)
// EOI    | emitting the EOI word, then pulsing frame_done
module jpeg_stream_sequencer
  import jpeg_pkg::*;
#(
  parameter int HDR_WORDS    = 156,
  parameter int HDR_AW       = 8,
  parameter int ISSUE_GAP    = 8,
  parameter int RST_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic [HDR_AW-1:0] hdr_addr,
  input  logic [31:0]       hdr_data,
  input  logic              ent_valid,
  output logic              ent_ready,
  input  logic [31:0]       ent_data,
  input  logic              ent_mcu_end,
  input  logic              ent_last,
  output logic              enqueue,
  output logic [31:0]       wdata,
  output logic [31:0]       wdata_nostuff,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HDR_WORDS - 1);

  state_t            state, state_n;
  logic              permit, hs;
  logic              hdr_vld, hdr_vld_n;
  logic              eoi_sent, eoi_sent_n;
  logic [HDR_AW-1:0] hdr_addr_n;
  logic              enqueue_n, busy_n, frame_done_n;
  logic [31:0]       wdata_n, wdata_nostuff_n;

`ifdef JPEG_RESTART_EN
  logic [15:0] mcu_cnt, mcu_cnt_n, mcu_inc;
  logic [2:0]  ridx, ridx_n;
  assign mcu_inc = mcu_cnt + 16'd1;
`else
  logic unused_mcu_end;
  assign unused_mcu_end = ent_mcu_end;
`endif

  // Ready is offered only in cycles a push is allowed, so a handshake always fits the pacing.
  assign ent_ready = (state == S_SCAN) && permit;
  assign hs        = ent_valid && ent_ready;

  jpeg_issue_pacer #(.ISSUE_GAP(ISSUE_GAP)) u_pacer (
    .clk    (clk),
    .rst_n  (rst_n),
    .fire   (enqueue_n),
    .permit (permit)
  );

  always_comb begin
    state_n         = state;
    hdr_addr_n      = hdr_addr;
    hdr_vld_n       = 1'b0;
    eoi_sent_n      = eoi_sent;
    enqueue_n       = 1'b0;
    wdata_n         = wdata;
    wdata_nostuff_n = wdata_nostuff;
    busy_n          = busy;
    frame_done_n    = 1'b0;
`ifdef JPEG_RESTART_EN
    mcu_cnt_n       = mcu_cnt;
    ridx_n          = ridx;
`endif
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          busy_n     = 1'b1;
          hdr_addr_n = '0;
          state_n    = S_HDR;
        end
      end
      S_HDR: begin
        // ROM data is valid one cycle after the address has been held steady.
        hdr_vld_n = 1'b1;
        if (hdr_vld && permit) begin
          enqueue_n       = 1'b1;
          wdata_n         = hdr_data;
          wdata_nostuff_n = NOSTUFF_ALL;
          hdr_vld_n       = 1'b0;
          if (hdr_addr == HDR_LAST) begin
            hdr_addr_n = '0;
            state_n    = S_SCAN;
          end else begin
            hdr_addr_n = hdr_addr + HDR_AW'(1);
          end
        end
      end
      S_SCAN: begin
        if (hs) begin
          enqueue_n       = 1'b1;
          wdata_n         = ent_data;
          wdata_nostuff_n = '0;
          if (ent_last) begin
            state_n = S_EOI;
          end
`ifdef JPEG_RESTART_EN
          else if (ent_mcu_end) begin
            mcu_cnt_n = mcu_inc;
            if (mcu_inc == 16'(RST_INTERVAL)) state_n = S_RST;
          end
`endif
        end
      end
`ifdef JPEG_RESTART_EN
      S_RST: begin
        if (permit) begin
          enqueue_n       = 1'b1;
          wdata_n         = {FILL, FILL, FILL, RST0[7:3], ridx};
          wdata_nostuff_n = NOSTUFF_ALL;
          ridx_n          = ridx + 3'd1;
          mcu_cnt_n       = '0;
          state_n         = S_SCAN;
        end
      end
`endif
      S_EOI: begin
        if (eoi_sent) begin
          frame_done_n = 1'b1;
          busy_n       = 1'b0;
          eoi_sent_n   = 1'b0;
          state_n      = S_IDLE;
`ifdef JPEG_RESTART_EN
          mcu_cnt_n    = '0;
          ridx_n       = '0;
`endif
        end else if (permit) begin
          enqueue_n       = 1'b1;
          wdata_n         = {FILL, FILL, FILL, EOI};
          wdata_nostuff_n = NOSTUFF_ALL;
          eoi_sent_n      = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      hdr_addr      <= '0;
      hdr_vld       <= 1'b0;
      eoi_sent      <= 1'b0;
      enqueue       <= 1'b0;
      wdata         <= '0;
      wdata_nostuff <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
`ifdef JPEG_RESTART_EN
      mcu_cnt       <= '0;
      ridx          <= '0;
`endif
    end else begin
      state         <= state_n;
      hdr_addr      <= hdr_addr_n;
      hdr_vld       <= hdr_vld_n;
      eoi_sent      <= eoi_sent_n;
      enqueue       <= enqueue_n;
      wdata         <= wdata_n;
      wdata_nostuff <= wdata_nostuff_n;
      busy          <= busy_n;
      frame_done    <= frame_done_n;
`ifdef JPEG_RESTART_EN
      mcu_cnt       <= mcu_cnt_n;
      ridx          <= ridx_n;
`endif
    end
  end

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Scoreboard bench for jpeg_stream_sequencer: expected words are queued at stimulus time and
// checked against every enqueue; restart markers are expected only when JPEG_RESTART_EN is defined.
module tb_jpeg_stream_sequencer;

  localparam int HDR_WORDS    = 4;
  localparam int HDR_AW       = 8;
  localparam int ISSUE_GAP    = 8;
  localparam int RST_INTERVAL = 2;

  logic              clk, rst_n, frame_start;
  logic [HDR_AW-1:0] hdr_addr;
  logic [31:0]       hdr_data;
  logic              ent_valid, ent_ready, ent_mcu_end, ent_last;
  logic [31:0]       ent_data;
  logic              enqueue, busy, frame_done;
  logic [31:0]       wdata, wdata_nostuff;

  jpeg_stream_sequencer #(
    .HDR_WORDS(HDR_WORDS), .HDR_AW(HDR_AW), .ISSUE_GAP(ISSUE_GAP), .RST_INTERVAL(RST_INTERVAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_data(ent_data),
    .ent_mcu_end(ent_mcu_end), .ent_last(ent_last),
    .enqueue(enqueue), .wdata(wdata), .wdata_nostuff(wdata_nostuff),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous header ROM holding addr+1.
  always @(posedge clk) hdr_data <= 32'(hdr_addr) + 32'd1;

  typedef struct {
    logic [31:0] d;
    logic [31:0] ns;
    bit          exact;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_enq_cyc = 0;
  bit   prev_valid = 0;
  int   m_cnt = 0;
  int   m_ridx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] ns, input bit exact);
    exp_t e;
    e.d = d; e.ns = ns; e.exact = exact;
    q.push_back(e);
  endtask

  // Output monitor: pops the scoreboard on every enqueue and checks pacing and frame_done timing.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (enqueue) begin
        if (q.size() == 0) begin
          chk("unexpected_enqueue", wdata, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wdata", wdata, e.d);
          chk("nostuff", wdata_nostuff, e.ns);
          if (prev_valid) begin
            if (e.exact) chk("gap_exact", 32'(cyc - last_enq_cyc), 32'(ISSUE_GAP));
            else         chk("gap_min", 32'(cyc - last_enq_cyc >= ISSUE_GAP), 32'd1);
          end
        end
        last_enq_cyc = cyc;
        prev_valid   = 1'b1;
      end
      if (frame_done) begin
        chk("done_after_eoi", 32'(last_enq_cyc), 32'(cyc - 1));
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_frame();
    frame_start = 1'b1;
    for (int i = 0; i < HDR_WORDS; i++) push(32'(i + 1), 32'h8080_8080, i != 0);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit me, input bit last, input int stall);
    int n;
    repeat (stall) @(negedge clk);
    ent_valid = 1'b1; ent_data = d; ent_mcu_end = me; ent_last = last;
    n = 0;
    while (!ent_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ent_ready_seen", 32'(ent_ready), 32'd1);
    push(d, 32'h0, 1'b0);
    if (last) begin
      push(32'hFFFF_FFD9, 32'h8080_8080, 1'b0);
      m_cnt = 0; m_ridx = 0;
    end else if (me) begin
`ifdef JPEG_RESTART_EN
      m_cnt++;
      if (m_cnt == RST_INTERVAL) begin
        push({24'hFFFFFF, 5'b11010, 3'(m_ridx)}, 32'h8080_8080, 1'b0);
        m_ridx = (m_ridx + 1) % 8;
        m_cnt  = 0;
      end
`endif
    end
    @(negedge clk);
    ent_valid = 1'b0; ent_mcu_end = 1'b0; ent_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(frame_done), 32'd1);
    chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_pulse"}, 32'(frame_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; frame_start = 1'b0; ent_valid = 1'b0; ent_data = '0;
    ent_mcu_end = 1'b0; ent_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enqueue", 32'(enqueue), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ent_ready", 32'(ent_ready), 32'd0);
    chk("rst_hdr_addr", 32'(hdr_addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_nostuff", wdata_nostuff, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: header, then three entropy words with valid held high.
    start_frame();
    chk("busy_after_start", 32'(busy), 32'd1);
    send(32'hA1B2_C3D4, 1'b0, 1'b0, 0);
    send(32'h00FF_1234, 1'b0, 1'b0, 0);
    send(32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    wait_done("f1");

    // Frame 2: random stalls on ent_valid, every word ends an MCU.
    start_frame();
    for (int i = 0; i < 6; i++)
      send($urandom, 1'b1, i == 5, $urandom_range(0, 12));
    wait_done("f2");

    // Frame 3: five one-word MCUs, last on the fifth.
    start_frame();
    for (int i = 0; i < 5; i++)
      send(32'hFF00_0000 | 32'(i), 1'b1, i == 4, 0);
    wait_done("f3");

    // Frame 4: second frame_start while busy is ignored; reset asserted during SCAN.
    start_frame();
    repeat (5) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    send(32'h1234_5678, 1'b0, 1'b0, 0);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("f4_words_drained", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("f4_busy_in_scan", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_enqueue", 32'(enqueue), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ent_ready", 32'(ent_ready), 32'd0);
    chk("midrst_hdr_addr", 32'(hdr_addr), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    chk("midrst_nostuff", wdata_nostuff, 32'd0);
    q.delete();
    prev_valid = 1'b0; m_cnt = 0; m_ridx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    // Frame 5: normal operation after reset.
    start_frame();
    send(32'hCAFE_F00D, 1'b1, 1'b1, 0);
    wait_done("f5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
